vga_vram_reader: RTL and testbench

Display-side reader for the video RAM: generates 640x480@60 Hz VGA timing from a 25 MHz pixel clock, scans the frame buffer through the RAM's read port, and drives RGB plus sync to the pins. The CPU-side writer keeps the write port; this block owns only the read address and consumes the registered read data one cycle later. The frame buffer is low-resolution: each VRAM word is one RGB pixel covering a 2^SCALE_SHIFT x 2^SCALE_SHIFT screen block.

---
 rtl/vga_vram_reader.sv | 120 ++++++++++++
 tb/tb_vga_vram_reader.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/vga_vram_reader.sv
// VGA 640x480@60 display reader: timing counters, VRAM read addressing
// and a 3-stage aligned pipeline from counter state to RGB/sync pins.
module vga_vram_reader #(
    parameter int H_VISIBLE   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int SCALE_SHIFT = 3,
    parameter int COL_BITS    = 7,
    parameter int ROW_BITS    = 6,
    parameter int ADDR_WIDTH  = 13,
    parameter int DATA_WIDTH  = 3
) (
    input  logic                  Clock,
    input  logic                  Reset,
    output logic [ADDR_WIDTH-1:0] oReadAddress,
    input  logic [DATA_WIDTH-1:0] iReadData,
    output logic                  oRed,
    output logic                  oGreen,
    output logic                  oBlue,
    output logic                  oHSync,
    output logic                  oVSync,
    output logic                  oVBlank,
    output logic                  oFrameStart
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    typedef struct packed {
        logic vis;
        logic hs_n;
        logic vs_n;
        logic vb;
        logic f0;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{vis: 1'b0, hs_n: 1'b1, vs_n: 1'b1,
                                    vb: 1'b0, f0: 1'b0};

    logic [9:0] r_hc;
    logic [9:0] r_vc;
    ctrl_t      r_ctl1;
    ctrl_t      r_ctl2;

    ctrl_t                 w_ctl0;
    logic [ADDR_WIDTH-1:0] w_addr;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_hc <= '0;
            r_vc <= '0;
        end else if (r_hc == H_LAST) begin
            r_hc <= '0;
            r_vc <= (r_vc == V_LAST) ? 10'd0 : r_vc + 10'd1;
        end else begin
            r_hc <= r_hc + 10'd1;
        end
    end

    always_comb begin
        w_ctl0      = CTRL_IDLE;
        w_ctl0.vis  = (r_hc < H_VIS) && (r_vc < V_VIS);
        w_ctl0.hs_n = !((r_hc >= HS_FIRST) && (r_hc <= HS_LAST));
        w_ctl0.vs_n = !((r_vc >= VS_FIRST) && (r_vc <= VS_LAST));
        w_ctl0.vb   = (r_vc >= V_VIS);
        w_ctl0.f0   = (r_hc == 10'd0) && (r_vc == 10'd0);
    end

    // Block row/column are plain bit fields of the counters; no multiply.
    assign w_addr = {r_vc[SCALE_SHIFT +: ROW_BITS],
                     r_hc[SCALE_SHIFT +: COL_BITS]};

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            oReadAddress <= '0;
            r_ctl1       <= CTRL_IDLE;
            r_ctl2       <= CTRL_IDLE;
        end else begin
            oReadAddress <= w_ctl0.vis ? w_addr : '0;
            r_ctl1       <= w_ctl0;
            r_ctl2       <= r_ctl1;
        end
    end

    // Stage 2 control lines up with the RAM's registered read data.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            oRed        <= 1'b0;
            oGreen      <= 1'b0;
            oBlue       <= 1'b0;
            oHSync      <= 1'b1;
            oVSync      <= 1'b1;
            oVBlank     <= 1'b0;
            oFrameStart <= 1'b0;
        end else begin
            oRed        <= r_ctl2.vis & iReadData[2];
            oGreen      <= r_ctl2.vis & iReadData[1];
            oBlue       <= r_ctl2.vis & iReadData[0];
            oHSync      <= r_ctl2.hs_n;
            oVSync      <= r_ctl2.vs_n;
            oVBlank     <= r_ctl2.vb;
            oFrameStart <= r_ctl2.f0;
        end
    end

endmodule

// File: tb/tb_vga_vram_reader.sv
// Bench for vga_vram_reader: full-size instance for line timing and
// addressing, shrunk-geometry instance for whole-frame behaviour.
module tb_vga_vram_reader;

    logic Clock = 1'b0;
    logic Reset = 1'b0;

    always #20 Clock = ~Clock;

    logic [12:0] addr_b, addr_s;
    logic [2:0]  rd_b, rd_s;
    logic        r_b, g_b, bl_b, hs_b, vs_b, vb_b, fs_b;
    logic        r_s, g_s, bl_s, hs_s, vs_s, vb_s, fs_s;

    logic [2:0] mem_s [0:8191];

    int checks = 0;
    int errors = 0;
    int n;

    vga_vram_reader u_big (
        .Clock(Clock), .Reset(Reset),
        .oReadAddress(addr_b), .iReadData(rd_b),
        .oRed(r_b), .oGreen(g_b), .oBlue(bl_b),
        .oHSync(hs_b), .oVSync(vs_b),
        .oVBlank(vb_b), .oFrameStart(fs_b)
    );

    vga_vram_reader #(
        .H_VISIBLE(64), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
        .V_VISIBLE(48), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
    ) u_small (
        .Clock(Clock), .Reset(Reset),
        .oReadAddress(addr_s), .iReadData(rd_s),
        .oRed(r_s), .oGreen(g_s), .oBlue(bl_s),
        .oHSync(hs_s), .oVSync(vs_s),
        .oVBlank(vb_s), .oFrameStart(fs_s)
    );

    // Synchronous-read RAMs: big one holds address[2:0], small one random.
    always @(posedge Clock) begin
        rd_b <= addr_b[2:0];
        rd_s <= mem_s[addr_s];
    end

    function automatic logic [2:0] mem_val(bit sm, int a);
        if (sm) return mem_s[a];
        return 3'(a % 8);
    endfunction

    // Expected {addr, rgb, hs, vs, vb, fs} after edge n since release.
    function automatic logic [19:0] expect_vec(bit sm, int n);
        int ht, vt, hv, vv, hs0, hsw, vs0, t, hc, vc;
        logic [12:0] a;
        logic [2:0]  c;
        logic        h, v, b, f;
        ht  = sm ? 80 : 800;
        vt  = sm ? 55 : 525;
        hv  = sm ? 64 : 640;
        vv  = sm ? 48 : 480;
        hs0 = sm ? 68 : 656;
        hsw = sm ? 8 : 96;
        vs0 = sm ? 50 : 490;
        a = '0; c = '0; h = 1'b1; v = 1'b1; b = 1'b0; f = 1'b0;
        if (n >= 1) begin
            t  = (n - 1) % (ht * vt);
            hc = t % ht;
            vc = t / ht;
            if (hc < hv && vc < vv) a = 13'((vc / 8) * 128 + hc / 8);
        end
        if (n >= 3) begin
            t  = (n - 3) % (ht * vt);
            hc = t % ht;
            vc = t / ht;
            if (hc < hv && vc < vv)
                c = mem_val(sm, (vc / 8) * 128 + hc / 8);
            h = !(hc >= hs0 && hc < hs0 + hsw);
            v = !(vc >= vs0 && vc < vs0 + 2);
            b = (vc >= vv);
            f = (hc == 0 && vc == 0);
        end
        return {a, c, h, v, b, f};
    endfunction

    function automatic logic [19:0] obs_vec(bit sm);
        if (sm)
            return {addr_s, r_s, g_s, bl_s, hs_s, vs_s, vb_s, fs_s};
        return {addr_b, r_b, g_b, bl_b, hs_b, vs_b, vb_b, fs_b};
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    int hs_falls[$];
    int hs_low_line0;
    int vs_low_s;
    int vs_fall_s[$];
    int fs_s_edges[$];
    int fs_b_edges[$];

    task automatic run(int len, int big_len);
        logic prev_hs_b, prev_vs_s;
        prev_hs_b = 1'b1;
        prev_vs_s = 1'b1;
        hs_falls.delete();
        vs_fall_s.delete();
        fs_s_edges.delete();
        fs_b_edges.delete();
        hs_low_line0 = 0;
        vs_low_s = 0;
        for (int k = 1; k <= len; k++) begin
            @(posedge Clock);
            n = k;
            @(negedge Clock);
            if (n == 4003) mem_s[130] = 3'b101;
            chk("small_pins", 32'(obs_vec(1'b1)), 32'(expect_vec(1'b1, n)));
            if (fs_s) fs_s_edges.push_back(n);
            if (!vs_s && n < 4403) vs_low_s++;
            if (prev_vs_s && !vs_s) vs_fall_s.push_back(n);
            prev_vs_s = vs_s;
            if (n <= big_len) begin
                chk("big_pins", 32'(obs_vec(1'b0)),
                    32'(expect_vec(1'b0, n)));
                if (fs_b) fs_b_edges.push_back(n);
                if (prev_hs_b && !hs_b) hs_falls.push_back(n);
                if (!hs_b && n < 1459) hs_low_line0++;
                prev_hs_b = hs_b;
                if (n == 7218) chk("addr_17_9", 32'(addr_b), 32'd130);
                if (n == 7219) chk("rgb_16_9", 32'({r_b, g_b, bl_b}), 32'd2);
                if (n == 7226) chk("rgb_23_9", 32'({r_b, g_b, bl_b}), 32'd2);
                if (n == 7227) chk("rgb_24_9", 32'({r_b, g_b, bl_b}), 32'd3);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem_s[i] = 3'($urandom);
        mem_s[130] = 3'b010;
        Reset = 1'b0;
        repeat (3) @(negedge Clock);
        chk("rst_big", 32'(obs_vec(1'b0)), 32'(expect_vec(1'b0, 0)));
        chk("rst_small", 32'(obs_vec(1'b1)), 32'(expect_vec(1'b1, 0)));
        Reset = 1'b1;

        run(10433, 9600);
        chk("hs_fall0", 32'(hs_falls.size() > 0 ? hs_falls[0] : -1), 32'd659);
        chk("hs_fall1", 32'(hs_falls.size() > 1 ? hs_falls[1] : -1), 32'd1459);
        chk("hs_low_len", 32'(hs_low_line0), 32'd96);
        chk("vs_fall_s", 32'(vs_fall_s.size() > 0 ? vs_fall_s[0] : -1),
            32'd4003);
        chk("vs_low_s", 32'(vs_low_s), 32'd160);
        chk("fs_b_cnt", 32'(fs_b_edges.size()), 32'd1);
        chk("fs_b_edge", 32'(fs_b_edges.size() > 0 ? fs_b_edges[0] : -1),
            32'd3);
        chk("fs_s_cnt", 32'(fs_s_edges.size()), 32'd3);
        chk("fs_s_per", 32'(fs_s_edges.size() > 2 ?
            fs_s_edges[2] - fs_s_edges[1] : -1), 32'd4400);

        #5 Reset = 1'b0;
        #1;
        chk("midrst_big", 32'(obs_vec(1'b0)), 32'(expect_vec(1'b0, 0)));
        chk("midrst_small", 32'(obs_vec(1'b1)), 32'(expect_vec(1'b1, 0)));
        #4 Reset = 1'b1;

        run(4500, 900);
        chk("re_fs_b", 32'(fs_b_edges.size() > 0 ? fs_b_edges[0] : -1),
            32'd3);
        chk("re_fs_s0", 32'(fs_s_edges.size() > 0 ? fs_s_edges[0] : -1),
            32'd3);
        chk("re_fs_s1", 32'(fs_s_edges.size() > 1 ? fs_s_edges[1] : -1),
            32'd4403);
        chk("re_hs_fall", 32'(hs_falls.size() > 0 ? hs_falls[0] : -1),
            32'd659);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
